// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: state encoding, default
// operand width and the step-counter sizing rule.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // The step counter must be able to count 0..WIDTH.
  function automatic int counter_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DEFAULT_CNT_WIDTH = counter_width(DEFAULT_WIDTH);

endpackage

// File: rtl/restoring_divider_trial_subtractor.sv
// Combinational trial subtractor: a + ~b + 1 as a ripple chain of full-adder
// cells. A missing carry-out means the subtraction borrowed (a < b).
module trial_subtractor
  import restoring_divider_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0]   carry;
  logic [N-1:0] b_inv;

  assign b_inv    = ~b;
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign diff[i]    = a[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b_inv[i]) | (a[i] & carry[i]) | (b_inv[i] & carry[i]);
  end

  assign borrow = ~carry[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider. One trial subtraction per cycle in
// CALC; a zero divisor skips straight to DONE with the fixed fallback result.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = counter_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    step_cnt;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [WIDTH-1:0] quo_reg;

  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic             take;
  logic [WIDTH:0]   next_rem;
  logic [WIDTH-1:0] next_quo;
  logic             last_step;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign shifted_rem = (part_rem << 1) | (WIDTH+1)'(dvd_reg[WIDTH-1]);

  trial_subtractor #(.N(WIDTH + 1)) u_trial (
    .a      (shifted_rem),
    .b      ({1'b0, dsr_reg}),
    .diff   (trial_diff),
    .borrow (trial_borrow)
  );

  // Keep the difference only when it did not borrow; that bit is the quotient bit.
  assign take      = ~trial_borrow;
  assign next_rem  = take ? trial_diff : shifted_rem;
  assign next_quo  = (quo_reg << 1) | WIDTH'(take);
  assign last_step = (step_cnt == CW'(WIDTH - 1));

  // FSM, shift registers and registered outputs, all updated together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step_cnt    <= '0;
      part_rem    <= '0;
      dvd_reg     <= '0;
      dsr_reg     <= '0;
      quo_reg     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_reg  <= dividend;
            dsr_reg  <= divisor;
            part_rem <= '0;
            quo_reg  <= '0;
            step_cnt <= '0;
            if (divisor != '0) begin
              state <= CALC;
              busy  <= 1'b1;
            end else begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          part_rem <= next_rem;
          dvd_reg  <= dvd_reg << 1;
          quo_reg  <= next_quo;
          step_cnt <= step_cnt + CW'(1);
          if (last_step) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= next_quo;
            remainder   <= next_rem[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
